// File: rtl/instr_encoder.sv
// instr_encoder: builds RV32I instruction words from a structured request
// and queues them in a small FIFO that writes into instruction memory at an
// auto-incrementing address.
// Optional feature macro: ENC_ALIGN_CHECK_EN rejects misaligned branch/jump
// immediates as invalid requests.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_restart,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [3:0]                i_class,
  input  logic [2:0]                i_funct3,
  input  logic                      i_funct7b5,
  input  logic [4:0]                i_rd,
  input  logic [4:0]                i_rs1,
  input  logic [4:0]                i_rs2,
  input  logic [31:0]               i_imm,
  output logic                      o_imem_we,
  output logic [31:0]               o_imem_addr,
  output logic [31:0]               o_imem_wdata,
  input  logic                      i_imem_ready,
  output logic                      o_err,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   head_addr;
  logic          err_flag;

  logic [31:0]   enc_word;
  logic          class_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic          bit30;

  // Combinational encoder: assemble the word for the requested class and
  // flag classes (or, optionally, immediates) that cannot be encoded.
  always_comb begin
    enc_word = 32'h0;
    class_ok = 1'b1;
    bit30    = (i_funct3 == 3'b101) ? i_funct7b5 : i_imm[10];
    case (i_class)
      4'd0: enc_word = {1'b0, i_funct7b5, 5'b00000, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
      4'd1: enc_word = {i_imm[11:0], i_rs1, 3'b010, i_rd, OP_LOAD};
      4'd2: enc_word = {i_imm[11], bit30, i_imm[9:0], i_rs1, i_funct3, i_rd, OP_IMM};
      4'd3: enc_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
      4'd4: enc_word = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OP_STORE};
      4'd5: enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
      4'd6: enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b000, i_imm[4:1],
                        i_imm[11], OP_BR};
      4'd7: enc_word = {i_imm[31:12], i_rd, OP_LUI};
      4'd8: enc_word = {i_imm[31:12], i_rd, OP_AUIPC};
      default: class_ok = 1'b0;
    endcase
`ifdef ENC_ALIGN_CHECK_EN
    if ((i_class == 4'd5 || i_class == 4'd6) && (i_imm[1:0] != 2'b00))
      class_ok = 1'b0;
    if ((i_class == 4'd3) && i_imm[0])
      class_ok = 1'b0;
`else
    class_ok = class_ok;
`endif
  end

  // Handshake qualifiers; restart overrides both the push and the pop.
  always_comb begin
    o_req_ready = (count < FULL_COUNT);
    accept      = i_req_valid && o_req_ready;
    push        = accept && class_ok && !i_restart;
    pop         = (count != '0) && i_imem_ready && !i_restart;
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= enc_word;
  end

  // Pointers, occupancy, head address and sticky error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_addr <= BASE_ADDR;
      err_flag  <= 1'b0;
    end else if (i_restart) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_addr <= BASE_ADDR;
      err_flag  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        head_addr <= head_addr + 32'd4;
      end
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (accept && !class_ok)
        err_flag <= 1'b1;
    end
  end

  // Memory-side view of the FIFO head.
  always_comb begin
    o_imem_we    = (count != '0);
    o_imem_addr  = head_addr;
    o_imem_wdata = o_imem_we ? mem[rd_ptr] : 32'h0;
    o_err        = err_flag;
    o_count      = count;
  end

endmodule
